// File: rtl/esc_cmd_serializer.sv
// Escape-command serializer for the C-PHY LP transmit path.
// Shifts a table-selected escape command out MSB first on SeqBit. The LPDT entry is followed
// by payload bytes sent LSB first, pulled through a valid/ready handshake with zero-gap
// prefetch. Optional macro ESC_CMD_SERIALIZER_ABORT_EN adds an Abort input and Aborted pulse.
module esc_cmd_serializer #(
  parameter int unsigned CMD_W = 8,
  parameter int unsigned NUM_CMD = 8,
  parameter logic [NUM_CMD*CMD_W-1:0] CMD_TABLE =
    {8'hA0, 8'h21, 8'h5D, 8'h62, 8'hDE, 8'h9F, 8'h1E, 8'hE1},
  parameter int unsigned LPDT_IDX = 0,
  localparam int unsigned SEL_W = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1
) (
  input  logic             RstN,
  input  logic             TxClkEsc,
  input  logic             CmdReq,
  input  logic [SEL_W-1:0] CmdSel,
  output logic             CmdAck,
  output logic             CmdErr,
  input  logic [7:0]       PayloadData,
  input  logic             PayloadValid,
  input  logic             PayloadLast,
  output logic             PayloadReady,
  output logic             SeqBit,
  output logic             SeqValid,
  output logic             CmdDone,
  output logic             Busy
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
  ,
  input  logic             Abort,
  output logic             Aborted
`endif
);

  localparam int unsigned CNT_W = $clog2(CMD_W) + 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StWait} stateT;

  stateT            state;
  logic [CNT_W-1:0] bitCnt;    // command bits already driven
  logic [CMD_W-1:0] cmdShift;  // command bits still to send, next one at MSB
  logic [7:0]       byteShift; // payload bits still to send, next one at LSB
  logic [2:0]       byteCnt;   // index of payload bit currently on SeqBit
  logic             lastByte;
  logic             isLpdt;

  logic [CMD_W-1:0] tableEntry;
  logic             selValid;
  logic             selLpdt;
  logic             cmdFinal;
  logic             byteFinal;
  logic             txnEnd;
  logic             prefetch;
  logic             abortNow;
  logic             xfer;

  // Look up the requested table entry; out-of-range selects yield zero and are rejected.
  always_comb begin
    tableEntry = '0;
    for (int unsigned i = 0; i < NUM_CMD; i++) begin
      if (32'(CmdSel) == i) tableEntry = CMD_TABLE[i*CMD_W +: CMD_W];
    end
  end

  // Decode where the transaction stands and whether a payload byte may be taken this cycle.
  always_comb begin
    selValid  = 32'(CmdSel) < NUM_CMD;
    selLpdt   = 32'(CmdSel) == LPDT_IDX;
    cmdFinal  = (state == StCmd) && (bitCnt == CNT_W'(CMD_W));
    byteFinal = (state == StData) && (byteCnt == 3'd7);
    txnEnd    = (cmdFinal && !isLpdt) || (byteFinal && lastByte);
    prefetch  = (cmdFinal && isLpdt) || (byteFinal && !lastByte) || (state == StWait);
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
    abortNow     = Abort && Busy;
    PayloadReady = prefetch && !Abort;
`else
    abortNow     = 1'b0;
    PayloadReady = prefetch;
`endif
    xfer = PayloadValid && PayloadReady;
  end

  // Sequencer: accepts commands, shifts command and payload bits, registers all status pulses.
  always_ff @(posedge TxClkEsc or negedge RstN) begin
    if (!RstN) begin
      state     <= StIdle;
      bitCnt    <= '0;
      cmdShift  <= '0;
      byteShift <= '0;
      byteCnt   <= '0;
      lastByte  <= 1'b0;
      isLpdt    <= 1'b0;
      CmdAck    <= 1'b0;
      CmdErr    <= 1'b0;
      SeqBit    <= 1'b0;
      SeqValid  <= 1'b0;
      CmdDone   <= 1'b0;
      Busy      <= 1'b0;
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
      Aborted   <= 1'b0;
`endif
    end else begin
      CmdAck  <= 1'b0;
      CmdErr  <= 1'b0;
      CmdDone <= 1'b0;
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
      Aborted <= 1'b0;
`endif
      if (abortNow) begin
        state    <= StIdle;
        SeqValid <= 1'b0;
        SeqBit   <= 1'b0;
        Busy     <= 1'b0;
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
        Aborted  <= 1'b1;
`endif
      end else if (state == StIdle || txnEnd) begin
        // Idle behaviour, also taken on the edge after a final bit so requests chain gap-free.
        state    <= StIdle;
        SeqValid <= 1'b0;
        SeqBit   <= 1'b0;
        Busy     <= 1'b0;
        if (CmdReq) begin
          if (!selValid) begin
            CmdErr <= 1'b1;
          end else begin
            CmdAck   <= 1'b1;
            SeqBit   <= tableEntry[CMD_W-1];
            cmdShift <= tableEntry << 1;
            SeqValid <= 1'b1;
            Busy     <= 1'b1;
            isLpdt   <= selLpdt;
            bitCnt   <= CNT_W'(1);
            state    <= StCmd;
            CmdDone  <= (CMD_W == 1) && !selLpdt;
          end
        end
      end else if (xfer) begin
        SeqBit    <= PayloadData[0];
        byteShift <= PayloadData >> 1;
        byteCnt   <= 3'd0;
        lastByte  <= PayloadLast;
        SeqValid  <= 1'b1;
        state     <= StData;
      end else if (prefetch) begin
        state    <= StWait;
        SeqValid <= 1'b0;
        SeqBit   <= 1'b0;
      end else begin
        case (state)
          StCmd: begin
            SeqBit   <= cmdShift[CMD_W-1];
            cmdShift <= cmdShift << 1;
            bitCnt   <= bitCnt + CNT_W'(1);
            CmdDone  <= !isLpdt && (bitCnt == CNT_W'(CMD_W - 1));
          end
          StData: begin
            SeqBit    <= byteShift[0];
            byteShift <= byteShift >> 1;
            byteCnt   <= byteCnt + 3'd1;
            CmdDone   <= lastByte && (byteCnt == 3'd6);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esc_cmd_serializer.sv
// Bench for esc_cmd_serializer: a queue-based transaction model predicts every output each
// cycle, and directed scenarios pin captured bit streams to hand-computed literals.
module tb_esc_cmd_serializer;

  logic       RstN = 1'b0;
  logic       TxClkEsc = 1'b0;
  logic       CmdReq = 1'b0;
  logic [2:0] CmdSel = 3'd0;
  logic [7:0] PayloadData = 8'd0;
  logic       PayloadValid = 1'b0;
  logic       PayloadLast = 1'b0;
  logic       CmdAck, CmdErr, PayloadReady, SeqBit, SeqValid, CmdDone, Busy;
  logic       AbortV = 1'b0;
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
  logic       Aborted;
  logic       Aborted2;
`endif

  logic       CmdReq2 = 1'b0;
  logic [2:0] CmdSel2 = 3'd0;
  logic       CmdAck2, CmdErr2, PayloadReady2, SeqBit2, SeqValid2, CmdDone2, Busy2;

  esc_cmd_serializer dut (
    .RstN(RstN), .TxClkEsc(TxClkEsc), .CmdReq(CmdReq), .CmdSel(CmdSel),
    .CmdAck(CmdAck), .CmdErr(CmdErr), .PayloadData(PayloadData),
    .PayloadValid(PayloadValid), .PayloadLast(PayloadLast), .PayloadReady(PayloadReady),
    .SeqBit(SeqBit), .SeqValid(SeqValid), .CmdDone(CmdDone), .Busy(Busy)
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
    , .Abort(AbortV), .Aborted(Aborted)
`endif
  );

  esc_cmd_serializer #(
    .NUM_CMD(6),
    .CMD_TABLE({8'h5D, 8'h62, 8'hDE, 8'h9F, 8'h1E, 8'hE1})
  ) dut2 (
    .RstN(RstN), .TxClkEsc(TxClkEsc), .CmdReq(CmdReq2), .CmdSel(CmdSel2),
    .CmdAck(CmdAck2), .CmdErr(CmdErr2), .PayloadData(8'd0),
    .PayloadValid(1'b0), .PayloadLast(1'b0), .PayloadReady(PayloadReady2),
    .SeqBit(SeqBit2), .SeqValid(SeqValid2), .CmdDone(CmdDone2), .Busy(Busy2)
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
    , .Abort(1'b0), .Aborted(Aborted2)
`endif
  );

  always #5 TxClkEsc = ~TxClkEsc;

  int nChk = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

  // Observation counters, cleared per scenario.
  logic [63:0] cap = '0;
  int capN = 0, doneCnt = 0, ackCnt = 0, waitCnt = 0, abortCnt = 0, cyc = 0;
  int ackCyc[4];

  // Reference model state: bits still to emit plus what is currently being driven.
  bit   q[$];
  logic mAck = 0, mErr = 0, mBit = 0, mValid = 0, mDone = 0, mBusy = 0, mMore = 0;
  logic mAborted = 0;

  function automatic logic [7:0] cmdCode(input int sel);
    case (sel)
      0: return 8'hE1;
      1: return 8'h1E;
      2: return 8'h9F;
      3: return 8'hDE;
      4: return 8'h62;
      5: return 8'h5D;
      6: return 8'h21;
      default: return 8'hA0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge TxClkEsc or negedge RstN);
    if (!RstN) begin
      q.delete();
      {mAck, mErr, mBit, mValid, mDone, mBusy, mMore, mAborted} = '0;
    end else begin
      cyc++;
      {mAck, mErr, mDone, mAborted} = '0;
      if (AbortV && mBusy) begin
        q.delete();
        {mBit, mValid, mBusy, mMore} = '0;
        mAborted = 1'b1;
      end else if (q.size() > 0) begin
        mBit = q.pop_front();
        mValid = 1'b1;
        mDone = (q.size() == 0) && !mMore;
      end else if (mBusy && mMore) begin
        if (PayloadValid) begin
          for (int i = 0; i < 8; i++) q.push_back(PayloadData[i]);
          mMore = !PayloadLast;
          mBit = q.pop_front();
          mValid = 1'b1;
        end else begin
          mBit = 1'b0;
          mValid = 1'b0;
        end
      end else begin
        {mBit, mValid, mBusy} = '0;
        if (CmdReq) begin
          if (int'(CmdSel) >= 8) begin
            mErr = 1'b1;
          end else begin
            logic [7:0] code;
            code = cmdCode(int'(CmdSel));
            mAck = 1'b1;
            for (int i = 7; i >= 0; i--) q.push_back(code[i]);
            mMore = (CmdSel == 3'd0);
            mBit = q.pop_front();
            mValid = 1'b1;
            mBusy = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus capture of the live bit stream.
  initial forever begin
    @(negedge TxClkEsc);
    if (chkEn) begin
      logic [7:0] act, exp;
      exp = {mAck, mErr, mBit, mValid, mDone, mBusy,
             mBusy && (q.size() == 0) && mMore && !AbortV, 1'b0};
      act = {CmdAck, CmdErr, SeqBit, SeqValid, CmdDone, Busy, PayloadReady, 1'b0};
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
      exp[0] = mAborted;
      act[0] = Aborted;
`endif
      nChk++;
      if (act !== exp) begin
        nFail++;
        $display("FAIL model t=%0t ack,err,bit,valid,done,busy,ready,abrt got %b expected %b",
                 $time, act, exp);
      end
    end
    if (RstN) begin
      if (SeqValid) begin
        cap = {cap[62:0], SeqBit};
        capN++;
      end
      if (CmdDone) doneCnt++;
      if (CmdAck) begin
        if (ackCnt < 4) ackCyc[ackCnt] = cyc;
        ackCnt++;
      end
      if (Busy && !SeqValid) waitCnt++;
`ifdef ESC_CMD_SERIALIZER_ABORT_EN
      if (Aborted) abortCnt++;
`endif
    end
  end

  task automatic clearCap();
    cap = '0;
    capN = 0; doneCnt = 0; ackCnt = 0; waitCnt = 0; abortCnt = 0;
  endtask

  task automatic waitIdle(input string name, input int limit);
    bit idle = 1'b0;
    for (int c = 0; c < limit && !idle; c++) begin
      @(negedge TxClkEsc);
      idle = !Busy;
    end
    check({name, " idle within budget"}, 64'(idle), 64'd1);
  endtask

  task automatic issue(input logic [2:0] sel);
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b1;
    CmdSel = sel;
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b0;
  endtask

  // LPDT with two payload bytes; the first byte is offered only after holdOff ready cycles.
  task automatic runLpdt(input logic [7:0] b0, input logic [7:0] b1, input int holdOff);
    int idx = 0;
    int idleRdy = 0;
    bit hs;
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b1;
    CmdSel = 3'd0;
    if (holdOff == 0) begin
      PayloadData = b0; PayloadValid = 1'b1; PayloadLast = 1'b0;
    end
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b0;
    for (int c = 0; c < 200 && idx < 2; c++) begin
      @(negedge TxClkEsc);
      hs = PayloadValid && PayloadReady;
      if (PayloadReady && !PayloadValid) idleRdy++;
      @(posedge TxClkEsc); #1;
      if (hs) begin
        idx++;
        if (idx == 1) begin
          PayloadData = b1; PayloadValid = 1'b1; PayloadLast = 1'b1;
        end else begin
          PayloadValid = 1'b0; PayloadLast = 1'b0;
        end
      end else if (idx == 0 && !PayloadValid && idleRdy >= holdOff) begin
        PayloadData = b0; PayloadValid = 1'b1; PayloadLast = 1'b0;
      end
    end
    check("lpdt both bytes taken", 64'(idx), 64'd2);
  endtask

  initial begin
    repeat (3) @(posedge TxClkEsc);
    #1;
    check("reset outputs", 64'({CmdAck, CmdErr, CmdDone, SeqBit, SeqValid, Busy, PayloadReady}),
          64'd0);
    check("reset outputs dut2", 64'({CmdAck2, CmdErr2, CmdDone2, SeqValid2, Busy2}), 64'd0);
    RstN = 1'b1;
    chkEn = 1'b1;

    // Plain command, entry 1 = 0x1E.
    clearCap();
    issue(3'd1);
    waitIdle("cmd1", 40);
    check("cmd1 bits", cap[7:0], 64'h1E);
    check("cmd1 bit count", 64'(capN), 64'd8);
    check("cmd1 done count", 64'(doneCnt), 64'd1);
    check("cmd1 ack count", 64'(ackCnt), 64'd1);

    // LPDT with payload presented early: 24 contiguous bits.
    clearCap();
    runLpdt(8'hA5, 8'h3C, 0);
    waitIdle("lpdt early", 60);
    check("lpdt early bits", cap[23:0], 64'hE1A53C);
    check("lpdt early bit count", 64'(capN), 64'd24);
    check("lpdt early gaps", 64'(waitCnt), 64'd0);
    check("lpdt early done count", 64'(doneCnt), 64'd1);

    // LPDT with payload withheld: three WAIT cycles, then 0x0F and 0x80 LSB first.
    clearCap();
    runLpdt(8'h0F, 8'h80, 3);
    waitIdle("lpdt late", 60);
    check("lpdt late bits", cap[23:0], 64'hE1F001);
    check("lpdt late bit count", 64'(capN), 64'd24);
    check("lpdt late wait cycles", 64'(waitCnt), 64'd3);
    check("lpdt late done count", 64'(doneCnt), 64'd1);

    // Back-to-back: second command (entry 4 = 0x62) follows with no gap.
    clearCap();
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b1;
    CmdSel = 3'd1;
    @(posedge TxClkEsc); #1;
    CmdSel = 3'd4;
    for (int c = 0; c < 40 && ackCnt < 2; c++) @(negedge TxClkEsc);
    @(posedge TxClkEsc); #1;
    CmdReq = 1'b0;
    waitIdle("b2b", 40);
    check("b2b bits", cap[15:0], 64'h1E62);
    check("b2b bit count", 64'(capN), 64'd16);
    check("b2b ack count", 64'(ackCnt), 64'd2);
    check("b2b ack spacing", 64'(ackCyc[1] - ackCyc[0]), 64'd8);
    check("b2b gaps", 64'(waitCnt), 64'd0);
    check("b2b done count", 64'(doneCnt), 64'd2);

`ifdef ESC_CMD_SERIALIZER_ABORT_EN
    // Abort on the edge that would drive bit 3.
    clearCap();
    issue(3'd1);
    @(posedge TxClkEsc); #1;
    AbortV = 1'b1;
    @(posedge TxClkEsc); #1;
    AbortV = 1'b0;
    check("abort valid dropped", 64'({SeqValid, Busy}), 64'd0);
    waitIdle("abort", 10);
    repeat (2) @(negedge TxClkEsc);
    check("abort bit count", 64'(capN), 64'd2);
    check("abort pulse count", 64'(abortCnt), 64'd1);
    check("abort done count", 64'(doneCnt), 64'd0);
`endif

    // Reset mid-command: outputs drop asynchronously, no CmdDone.
    clearCap();
    issue(3'd1);
    @(posedge TxClkEsc); #2;
    RstN = 1'b0;
    #1;
    check("async reset valid/busy", 64'({SeqValid, Busy}), 64'd0);
    @(posedge TxClkEsc); #1;
    RstN = 1'b1;
    repeat (3) @(negedge TxClkEsc);
    check("reset abort bit count", 64'(capN), 64'd1);
    check("reset abort done count", 64'(doneCnt), 64'd0);
    check("reset abort busy", 64'(Busy), 64'd0);

    // Six-entry instance: select 7 rejected, select 5 (0x5D, MSB 0) accepted.
    @(posedge TxClkEsc); #1;
    CmdReq2 = 1'b1;
    CmdSel2 = 3'd7;
    @(posedge TxClkEsc); #1;
    CmdReq2 = 1'b0;
    check("err pulse", 64'({CmdErr2, CmdAck2, SeqValid2, Busy2}), 64'b1000);
    @(posedge TxClkEsc); #1;
    check("err pulse single", 64'({CmdErr2, SeqValid2}), 64'd0);
    CmdReq2 = 1'b1;
    CmdSel2 = 3'd5;
    @(posedge TxClkEsc); #1;
    CmdReq2 = 1'b0;
    check("dut2 accept", 64'({CmdErr2, CmdAck2, SeqValid2, SeqBit2, Busy2}), 64'b01101);
    @(posedge TxClkEsc); #1;
    check("dut2 second bit", 64'({SeqValid2, SeqBit2}), 64'b11);
    for (int c = 0; c < 20 && Busy2; c++) @(posedge TxClkEsc);
    #1;
    check("dut2 finished", 64'(Busy2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule

// File: doc/esc_cmd_serializer.md
Name: esc_cmd_serializer

Overview:
- Parametrised successor to the fixed 8-entry escape-command sequencer for the C-PHY LP transmit path.
- Serialises a selectable escape command from a parameterised table onto a single LP bit stream at TxClkEsc.
- Accepts commands through a request/acknowledge handshake.
- For the LPDT entry, appends a byte payload stream, pulled through a valid/ready handshake, directly after the command bits.

Parameters:
- CMD_W, 8: bits per escape command.
- NUM_CMD, 8: number of table entries; SEL_W = max(1, clog2(NUM_CMD)) is a localparam.
- CMD_TABLE, {8'hA0,8'h21,8'h5D,8'h62,8'hDE,8'h9F,8'h1E,8'hE1}: flattened NUM_CMD*CMD_W table.
  - Entry i occupies bits [i*CMD_W +: CMD_W].
  - Entry MSB is transmitted first.
- LPDT_IDX, 0: table index that is followed by payload bytes.

Ports:
- RstN  in  1  asynchronous active-low reset
- TxClkEsc  in  1  escape-mode clock; all logic on its rising edge
- CmdReq  in  1  command request; level, sampled only when idle
- CmdSel  in  SEL_W  table index, sampled with CmdReq
- CmdAck  out  1  one-cycle pulse: request accepted
- CmdErr  out  1  one-cycle pulse: CmdSel >= NUM_CMD, request rejected
- PayloadData  in  8  LPDT byte, sent LSB first
- PayloadValid  in  1  payload byte valid
- PayloadLast  in  1  marks final payload byte; qualified by PayloadValid
- PayloadReady  out  1  combinational; byte transfers when PayloadValid && PayloadReady
- SeqBit  out  1  serial LP bit
- SeqValid  out  1  SeqBit carries a live bit this cycle
- CmdDone  out  1  one-cycle pulse coincident with the final bit of the transaction
- Busy  out  1  high from acceptance until the final bit has been driven

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-transfer aborts immediately; no CmdDone is produced.
- States: IDLE, CMD, DATA, WAIT. All outputs except PayloadReady are registered.
- IDLE, on an edge with CmdReq=1:
  - CmdSel >= NUM_CMD: CmdErr=1 for one cycle; stay IDLE; no bits sent.
  - Otherwise: CmdAck=1 for one cycle; load table entry; SeqBit=entry MSB, SeqValid=1, Busy=1; go to CMD with BitCnt=1.
- CMD: each edge drives the next entry bit, MSB to LSB. The final (CMD_W-th) bit is driven CMD_W-1 edges after acceptance.
  - Non-LPDT entry: CmdDone=1 alongside the final bit.
  - The following edge returns to IDLE behaviour: SeqValid=0, Busy=0, unless CmdReq=1, in which case the next command is accepted on that edge (back-to-back, zero gap).
- Payload prefetch: PayloadReady=1 combinationally during the final bit of an LPDT command, during bit 7 of a non-last payload byte, and throughout WAIT.
  - Handshake in the prefetch cycle: the next edge drives payload bit 0 with no gap (DATA).
  - No handshake in the prefetch cycle: the next edge enters WAIT.
- WAIT: SeqValid=0, SeqBit=0, Busy=1. The edge after the handshake drives bit 0 and enters DATA.
- DATA: 8 bits per byte, LSB first. PayloadLast is latched with the byte.
  - After bit 7 of the last byte: CmdDone=1 with that bit; the next edge behaves as IDLE.
- CmdReq is ignored while Busy. CmdSel changes while Busy have no effect.
- A payload handshake is impossible outside the prefetch windows, since PayloadReady=0 there.
- Counters: BitCnt is clog2(CMD_W)+1 wide; byte bit counter is 3 bits and wraps 7→0.

Optional Feature:
- Macro: ESC_CMD_SERIALIZER_ABORT_EN.
- Defined:
  - Adds input Abort (1 bit) and output Aborted (1 bit, registered, reset 0).
  - Abort=1 on any edge while Busy forces IDLE on that edge: SeqValid=0, SeqBit=0, Busy=0, Aborted=1 for one cycle, no CmdDone.
  - PayloadReady is 0 in the cycle Abort is high.
  - Abort in IDLE is ignored.
- Undefined: neither port exists; every accepted transaction runs to completion or reset.

Test Plan:
- Reset with all inputs 0 → every output 0. Assert RstN low mid-CMD → SeqValid and Busy drop asynchronously, no CmdDone.
- CmdReq=1, CmdSel=1 → CmdAck pulse; SeqBit stream 0,0,0,1,1,1,1,0 with SeqValid high for 8 cycles; CmdDone on the 8th bit; Busy low the cycle after.
- CmdSel=0 (LPDT), payload 8'hA5 then 8'h3C with PayloadLast, both presented valid early → bits 1,1,1,0,0,0,0,1, then 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0; 24 contiguous SeqValid cycles; single CmdDone on bit 24.
- LPDT with PayloadValid withheld 3 cycles after the command → 3 cycles SeqValid=0 in WAIT; first payload bit appears the edge after the handshake.
- Back-to-back: CmdReq held high with CmdSel=4 → second command 0,1,1,0,0,0,1,0 starts immediately after the first command's last bit; two CmdAck pulses 8 cycles apart.
- NUM_CMD=6, CmdSel=7 → CmdErr pulse, no CmdAck, SeqValid stays 0. With ABORT_EN defined: Abort on bit 3 → Aborted pulse, SeqValid=0 on that edge, no CmdDone.
